// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bundle: completion requests, CDB broadcast, issue allocation, RS occupancy.
// Latency: n/a (signal container only).
// Backpressure: requesters hold req_* until their grant bit is seen high.
interface cdb_arbiter_if #(
   parameter int DW = 16,
   parameter int TW = 3
);
   logic [TW-1:0] head_p;
   logic [2:0]    req_valid;
   logic [TW-1:0] req_rob0;
   logic [TW-1:0] req_rob1;
   logic [TW-1:0] req_rob2;
   logic [DW-1:0] req_val0;
   logic [DW-1:0] req_val1;
   logic [DW-1:0] req_val2;
   logic [2:0]    grant;
   logic          cdb_valid;
   logic [TW-1:0] cdb_rob;
   logic [DW-1:0] cdb_val;
   logic          issue_valid;
   logic [1:0]    issue_fu;
   logic          issue_accept;
   logic [1:0]    add_count;
   logic [1:0]    mul_count;
   logic [1:0]    bch_count;
   logic [2:0]    rs_full;

   // Driven by the functional units / issue stage
   modport master (
      output head_p, req_valid, req_rob0, req_rob1, req_rob2,
             req_val0, req_val1, req_val2, issue_valid, issue_fu,
      input  grant, cdb_valid, cdb_rob, cdb_val, issue_accept,
             add_count, mul_count, bch_count, rs_full
   );

   // Implemented by the arbiter
   modport slave (
      input  head_p, req_valid, req_rob0, req_rob1, req_rob2,
             req_val0, req_val1, req_val2, issue_valid, issue_fu,
      output grant, cdb_valid, cdb_rob, cdb_val, issue_accept,
             add_count, mul_count, bch_count, rs_full
   );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one of add/mul/bch onto the registered CDB and tracks RS occupancy.
// Latency: grant/issue_accept combinational; CDB and counters registered (1 cycle).
// Backpressure: ungranted requesters hold; issue refused when group full unless it drains now.
// Config: CDB_AGE_PRIO_EN selects oldest-tag-first (vs head_p); undefined selects round-robin.
module cdb_arbiter #(
   parameter int DW       = 16,
   parameter int TW       = 3,
   parameter int RS_DEPTH = 3
) (
   input  logic          i_clk1,
   input  logic          i_rst,
   input  logic          i_flush,
   cdb_arbiter_if.slave  bus
);

   localparam logic [1:0] LP_DEPTH = 2'(RS_DEPTH);

   logic          w_kill;
   logic [TW-1:0] w_rob [3];
   logic [DW-1:0] w_val [3];
   logic          w_found;
   logic [1:0]    w_sel;
   logic [2:0]    w_grant;
   logic [2:0]    w_inc;
   logic [2:0]    w_dec;

   logic          r_cdb_valid;
   logic [TW-1:0] r_cdb_rob;
   logic [DW-1:0] r_cdb_val;
   logic [1:0]    r_cnt [3];

   // rst and flush squash everything in the same cycle, including this cycle's grant/issue
   assign w_kill = i_rst | i_flush;

   assign w_rob[0] = bus.req_rob0;
   assign w_rob[1] = bus.req_rob1;
   assign w_rob[2] = bus.req_rob2;
   assign w_val[0] = bus.req_val0;
   assign w_val[1] = bus.req_val1;
   assign w_val[2] = bus.req_val2;

`ifdef CDB_AGE_PRIO_EN
   logic [TW-1:0] w_age [3];
   logic [TW-1:0] w_best;

   // Age is distance from the ROB head; the wrapping subtract handles tag rollover
   assign w_age[0] = w_rob[0] - bus.head_p;
   assign w_age[1] = w_rob[1] - bus.head_p;
   assign w_age[2] = w_rob[2] - bus.head_p;

   // Pick the youngest age (oldest instruction); strict compare keeps lower index on ties
   always_comb begin
      w_found = 1'b0;
      w_sel   = 2'd0;
      w_best  = '0;
      for (int i = 0; i < 3; i++) begin
         if (bus.req_valid[i] && (!w_found || (w_age[i] < w_best))) begin
            w_found = 1'b1;
            w_best  = w_age[i];
            w_sel   = 2'(i);
         end
      end
   end
`else
   logic [1:0] r_rr_last;
   logic [1:0] w_ord0;
   logic [1:0] w_ord1;
   logic [1:0] w_ord2;
   logic       w_unused_head;

   // head_p only matters for age ordering
   assign w_unused_head = ^bus.head_p;

   function automatic logic [1:0] f_next3(input logic [1:0] a);
      return (a >= 2'd2) ? 2'd0 : a + 2'd1;
   endfunction

   // Search order starts one past the last winner and wraps mod 3
   always_comb begin
      w_ord0  = f_next3(r_rr_last);
      w_ord1  = f_next3(w_ord0);
      w_ord2  = f_next3(w_ord1);
      w_found = 1'b0;
      w_sel   = 2'd0;
      if (bus.req_valid[w_ord0]) begin
         w_found = 1'b1;
         w_sel   = w_ord0;
      end else if (bus.req_valid[w_ord1]) begin
         w_found = 1'b1;
         w_sel   = w_ord1;
      end else if (bus.req_valid[w_ord2]) begin
         w_found = 1'b1;
         w_sel   = w_ord2;
      end
   end
`endif

   assign w_grant = (w_found && !w_kill) ? (3'b001 << w_sel) : 3'b000;

   // Allocation succeeds if the group has room or is draining an entry this same cycle
   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int g = 0; g < 3; g++) begin
         w_inc[g] = bus.issue_valid && !w_kill && (bus.issue_fu == 2'(g)) &&
                    ((r_cnt[g] < LP_DEPTH) || w_grant[g]);
         // A grant with nothing allocated is a protocol error: broadcast anyway, keep count at 0
         w_dec[g] = w_grant[g] && (r_cnt[g] != 2'd0);
      end
   end

   // CDB broadcast register, occupancy counters and round-robin pointer
   always_ff @(posedge i_clk1) begin
      if (w_kill) begin
         r_cdb_valid <= 1'b0;
         r_cdb_rob   <= '0;
         r_cdb_val   <= '0;
         for (int g = 0; g < 3; g++) r_cnt[g] <= 2'd0;
`ifndef CDB_AGE_PRIO_EN
         r_rr_last   <= 2'd2;
`endif
      end else begin
         if (|w_grant) begin
            r_cdb_valid <= 1'b1;
            r_cdb_rob   <= w_rob[w_sel];
            r_cdb_val   <= w_val[w_sel];
`ifndef CDB_AGE_PRIO_EN
            r_rr_last   <= w_sel;
`endif
         end else begin
            r_cdb_valid <= 1'b0;
         end
         for (int g = 0; g < 3; g++) begin
            if (w_inc[g] && !w_dec[g])
               r_cnt[g] <= r_cnt[g] + 2'd1;
            else if (w_dec[g] && !w_inc[g])
               r_cnt[g] <= r_cnt[g] - 2'd1;
         end
      end
   end

   assign bus.grant        = w_grant;
   assign bus.issue_accept = |w_inc;
   assign bus.cdb_valid    = r_cdb_valid;
   assign bus.cdb_rob      = r_cdb_rob;
   assign bus.cdb_val      = r_cdb_val;
   assign bus.add_count    = r_cnt[0];
   assign bus.mul_count    = r_cnt[1];
   assign bus.bch_count    = r_cnt[2];
   assign bus.rs_full      = {(r_cnt[2] == LP_DEPTH), (r_cnt[1] == LP_DEPTH), (r_cnt[0] == LP_DEPTH)};

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant order, CDB broadcast via scoreboard, occupancy counters.
// Latency checked: grant same cycle, CDB one cycle later, counters one cycle later.
// Backpressure checked: full-group refusal, same-cycle drain+issue, rst/flush squash.
module tb_cdb_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   cdb_arbiter_if #(.DW(16), .TW(3)) bus ();

   cdb_arbiter #(.DW(16), .TW(3), .RS_DEPTH(3)) dut (
      .i_clk1  (clk),
      .i_rst   (rst),
      .i_flush (flush),
      .bus     (bus)
   );

   typedef struct packed {
      logic        v;
      logic [2:0]  rob;
      logic [15:0] val;
   } cdb_t;

   cdb_t        sb_q[$];
   logic [2:0]  m_rob;
   logic [15:0] m_val;
   logic [2:0]  t_rob [3];
   logic [15:0] t_val [3];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [2:0] vld);
      bus.req_valid = vld;
      bus.req_rob0  = t_rob[0];
      bus.req_rob1  = t_rob[1];
      bus.req_rob2  = t_rob[2];
      bus.req_val0  = t_val[0];
      bus.req_val1  = t_val[1];
      bus.req_val2  = t_val[2];
   endtask

   // Check combinational outputs, predict the CDB, clock once, then compare the CDB
   task automatic cyc(input string tag, input logic [2:0] eg, input logic ea);
      cdb_t e;
      cdb_t a;
      int   idx;
      #1;
      chk({tag, "/grant"}, 32'(bus.grant), 32'(eg));
      chk({tag, "/accept"}, 32'(bus.issue_accept), 32'(ea));
      if (rst || flush) begin
         m_rob = '0;
         m_val = '0;
         e.v   = 1'b0;
      end else if (eg != 3'b000) begin
         idx   = eg[0] ? 0 : (eg[1] ? 1 : 2);
         m_rob = t_rob[idx];
         m_val = t_val[idx];
         e.v   = 1'b1;
      end else begin
         e.v   = 1'b0;
      end
      e.rob = m_rob;
      e.val = m_val;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      a.v   = bus.cdb_valid;
      a.rob = bus.cdb_rob;
      a.val = bus.cdb_val;
      e = sb_q.pop_front();
      chk({tag, "/cdb_valid"}, 32'(a.v), 32'(e.v));
      chk({tag, "/cdb_rob"}, 32'(a.rob), 32'(e.rob));
      chk({tag, "/cdb_val"}, 32'(a.val), 32'(e.val));
   endtask

   task automatic chk_cnt(input string tag, input logic [1:0] ea, input logic [1:0] em,
                          input logic [1:0] eb, input logic [2:0] ef);
      chk({tag, "/add_count"}, 32'(bus.add_count), 32'(ea));
      chk({tag, "/mul_count"}, 32'(bus.mul_count), 32'(em));
      chk({tag, "/bch_count"}, 32'(bus.bch_count), 32'(eb));
      chk({tag, "/rs_full"}, 32'(bus.rs_full), 32'(ef));
   endtask

   initial begin
      rst             = 1'b1;
      flush           = 1'b0;
      m_rob           = '0;
      m_val           = '0;
      bus.head_p      = 3'd0;
      bus.issue_valid = 1'b1;
      bus.issue_fu    = 2'd0;
      t_rob[0] = 3'd3; t_rob[1] = 3'd5; t_rob[2] = 3'd1;
      t_val[0] = 16'hA0A0; t_val[1] = 16'hB1B1; t_val[2] = 16'hC2C2;
      drive_req(3'b111);

      // Reset with every request and an issue pending: all squashed
      cyc("rst0", 3'b000, 1'b0);
      cyc("rst1", 3'b000, 1'b0);
      chk_cnt("rst", 2'd0, 2'd0, 2'd0, 3'b000);
      rst = 1'b0;
      bus.issue_valid = 1'b0;

`ifdef CDB_AGE_PRIO_EN
      // Ages from head 6: add 3, mul 1, bch 2 -> mul oldest
      bus.head_p = 3'd6;
      t_rob[0] = 3'd1; t_rob[1] = 3'd7; t_rob[2] = 3'd0;
      drive_req(3'b111);
      cyc("age_wrap", 3'b010, 1'b0);
      // Equal ages: lowest index wins
      bus.head_p = 3'd0;
      t_rob[0] = 3'd2; t_rob[1] = 3'd2; t_rob[2] = 3'd2;
      drive_req(3'b111);
      cyc("age_tie", 3'b001, 1'b0);
      drive_req(3'b000);
      cyc("age_idle", 3'b000, 1'b0);
`else
      // Round-robin from reset pointer 2: add, mul, bch, add
      cyc("rr1", 3'b001, 1'b0);
      cyc("rr2", 3'b010, 1'b0);
      cyc("rr3", 3'b100, 1'b0);
      t_rob[0] = 3'd4; t_val[0] = 16'hA1A1;
      drive_req(3'b111);
      cyc("rr4", 3'b001, 1'b0);
      // Last winner add: mul is searched first, but only add/bch request
      drive_req(3'b101);
      cyc("rr5", 3'b100, 1'b0);
      drive_req(3'b011);
      cyc("rr6", 3'b001, 1'b0);
      drive_req(3'b000);
      cyc("rr_idle", 3'b000, 1'b0);
`endif
      // Grants at zero occupancy must not underflow
      chk_cnt("no_underflow", 2'd0, 2'd0, 2'd0, 3'b000);

      // Fill add group, fourth issue refused
      bus.issue_valid = 1'b1;
      bus.issue_fu    = 2'd0;
      cyc("fill1", 3'b000, 1'b1);
      chk_cnt("fill1", 2'd1, 2'd0, 2'd0, 3'b000);
      cyc("fill2", 3'b000, 1'b1);
      chk_cnt("fill2", 2'd2, 2'd0, 2'd0, 3'b000);
      cyc("fill3", 3'b000, 1'b1);
      chk_cnt("fill3", 2'd3, 2'd0, 2'd0, 3'b001);
      cyc("fill4", 3'b000, 1'b0);
      chk_cnt("fill4", 2'd3, 2'd0, 2'd0, 3'b001);

      // Full group drains and allocates in the same cycle
      t_rob[0] = 3'd2; t_val[0] = 16'h1234;
      drive_req(3'b001);
      cyc("simul", 3'b001, 1'b1);
      chk_cnt("simul", 2'd3, 2'd0, 2'd0, 3'b001);
      bus.issue_valid = 1'b0;
      t_val[0] = 16'h5678;
      drive_req(3'b001);
      cyc("drain", 3'b001, 1'b0);
      chk_cnt("drain", 2'd2, 2'd0, 2'd0, 3'b000);

      // Build counts 2/1/3
      drive_req(3'b000);
      bus.issue_valid = 1'b1;
      bus.issue_fu    = 2'd1;
      cyc("mul1", 3'b000, 1'b1);
      bus.issue_fu = 2'd2;
      for (int i = 0; i < 3; i++) cyc("bch", 3'b000, 1'b1);
      chk_cnt("build", 2'd2, 2'd1, 2'd3, 3'b100);
      bus.issue_fu = 2'd3;
      cyc("fu_none", 3'b000, 1'b0);
      chk_cnt("fu_none", 2'd2, 2'd1, 2'd3, 3'b100);

      // Flush with a mul request and an issue pending
      bus.issue_fu = 2'd1;
      drive_req(3'b010);
      flush = 1'b1;
      cyc("flush", 3'b000, 1'b0);
      chk_cnt("flush", 2'd0, 2'd0, 2'd0, 3'b000);
      flush = 1'b0;
      bus.issue_valid = 1'b0;

      // After flush: add first in both modes (rr pointer back to 2 / add oldest)
      bus.head_p = 3'd0;
      t_rob[0] = 3'd0; t_rob[1] = 3'd1; t_rob[2] = 3'd2;
      t_val[0] = 16'h0F0F; t_val[1] = 16'h1E1E; t_val[2] = 16'h2D2D;
      drive_req(3'b111);
      cyc("post_flush", 3'b001, 1'b0);
      drive_req(3'b000);
      cyc("final_idle", 3'b000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
